// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, owner
// encodings and the default capture burst length.
package uart_tx_arbiter_pkg;

  localparam int MAX_BURST_DEFAULT = 16;

  localparam logic [1:0] OWNER_IDLE = 2'b00;
  localparam logic [1:0] OWNER_CPU  = 2'b01;
  localparam logic [1:0] OWNER_CAP  = 2'b10;

  // State codes double as the owner readback value.
  typedef enum logic [1:0] {
    ST_IDLE = OWNER_IDLE,
    ST_CPU  = OWNER_CPU,
    ST_CAP  = OWNER_CAP
  } state_t;

endpackage

// File: rtl/uart_tx_hold_reg.sv
// One-entry holding register for processor bytes with a sticky overrun flag.
// A write landing in the same cycle as a drain is accepted, not dropped.
module uart_tx_hold_reg
  import uart_tx_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_write,
  input  logic [7:0] cpu_data,
  input  logic       drain,
  input  logic       clr_overrun,
  output logic       pending,
  output logic [7:0] data,
  output logic       overrun
);

  logic load;
  logic drop;

  assign load = cpu_write && (!pending || drain);
  assign drop = cpu_write && pending && !drain;

  // Byte slot: load on a free or draining slot, otherwise empty on drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      data    <= 8'h00;
    end else if (load) begin
      pending <= 1'b1;
      data    <= cpu_data;
    end else if (drain) begin
      pending <= 1'b0;
    end
  end

  // Sticky overrun: a fresh drop beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)            overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates the UART transmit buffer between single processor bytes and
// capture-dump bursts. Round-robin on ties, at most one write every two
// cycles so the buffer full flag always has time to react.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_write,
  input  logic [7:0] cpu_data,
  input  logic       cap_valid,
  input  logic [7:0] cap_data,
  input  logic       cap_last,
  output logic       cap_ready,
  output logic [7:0] utx_data,
  output logic       utx_write,
  input  logic       utx_full,
  input  logic       utx_half_full,
  output logic [1:0] owner,
  output logic       cpu_pending,
  output logic       cpu_overrun,
  input  logic       clr_overrun
);

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_t     state;
  logic       last_cap;     // 1 when the most recent grant went to capture
  logic [7:0] burst_cnt;
  logic [7:0] hold_data;
  logic       write_ok;
  logic       cap_accept;
  logic       drain;

  // Half-full is status for the hub only; arbitration ignores it.
  logic unused_half_full;
  assign unused_half_full = utx_half_full;

  assign write_ok   = !utx_full && !utx_write;
  assign cap_ready  = (state == ST_CAP) && write_ok && !reset;
  assign cap_accept = cap_valid && cap_ready;
  assign drain      = (state == ST_CPU) && write_ok;
  assign owner      = state;

  uart_tx_hold_reg u_hold (
    .clk        (clk),
    .reset      (reset),
    .cpu_write  (cpu_write),
    .cpu_data   (cpu_data),
    .drain      (drain),
    .clr_overrun(clr_overrun),
    .pending    (cpu_pending),
    .data       (hold_data),
    .overrun    (cpu_overrun)
  );

  // Grant FSM with registered UART write strobe and byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      last_cap  <= 1'b1;
      utx_write <= 1'b0;
      utx_data  <= 8'h00;
      burst_cnt <= 8'h00;
    end else begin
      utx_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_pending && (!cap_valid || last_cap)) begin
            state    <= ST_CPU;
            last_cap <= 1'b0;
          end else if (cap_valid) begin
            state     <= ST_CAP;
            last_cap  <= 1'b1;
            burst_cnt <= 8'h00;
          end
        end
        ST_CPU: begin
          if (write_ok) begin
            utx_data  <= hold_data;
            utx_write <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_CAP: begin
          if (cap_accept) begin
            utx_data  <= cap_data;
            utx_write <= 1'b1;
            burst_cnt <= burst_cnt + 8'd1;
            if (cap_last || (burst_cnt + 8'd1) == BURST_MAX)
              state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with MAX_BURST=16.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_write = 1'b0;
  logic [7:0] cpu_data = 8'h00;
  logic       cap_valid = 1'b0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_last = 1'b0;
  logic       cap_ready;
  logic [7:0] utx_data;
  logic       utx_write;
  logic       utx_full = 1'b0;
  logic       utx_half_full = 1'b0;
  logic [1:0] owner;
  logic       cpu_pending;
  logic       cpu_overrun;
  logic       clr_overrun = 1'b0;

  int tests = 0;
  int fails = 0;

  uart_tx_arbiter #(.MAX_BURST(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_write(cpu_write), .cpu_data(cpu_data),
    .cap_valid(cap_valid), .cap_data(cap_data), .cap_last(cap_last),
    .cap_ready(cap_ready),
    .utx_data(utx_data), .utx_write(utx_write),
    .utx_full(utx_full), .utx_half_full(utx_half_full),
    .owner(owner), .cpu_pending(cpu_pending), .cpu_overrun(cpu_overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  // Write log, back-to-back detector, writes-under-full and per-grant accepts.
  logic [7:0] wq[$];
  int         grants[$];
  int         adj = 0;
  int         full_wr = 0;
  int         gcnt = 0;
  logic       in_cap = 1'b0;
  logic       prev_w = 1'b0;
  logic       prev_full = 1'b0;

  always @(negedge clk) begin
    if (utx_write) wq.push_back(utx_data);
    if (utx_write && prev_w) adj++;
    if (utx_write && utx_full && prev_full) full_wr++;
    prev_w    = utx_write;
    prev_full = utx_full;
    if (reset) begin
      gcnt   = 0;
      in_cap = 1'b0;
    end else if (owner == 2'b10) begin
      in_cap = 1'b1;
      if (cap_valid && cap_ready) gcnt++;
    end else if (in_cap) begin
      grants.push_back(gcnt);
      gcnt   = 0;
      in_cap = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Drive a capture frame of n bytes (base, base+1, ...), with utx_full high
  // for loop cycles [ffrom, fto). Returns accepted count and ready-while-full.
  task automatic send_cap(input int n, input logic [7:0] base, input int ffrom,
                          input int fto, output int sent, output int rwf);
    int   idx = 0;
    int   cyc = 0;
    logic acc;
    rwf = 0;
    while (idx < n && cyc < 2000) begin
      cap_valid = 1'b1;
      cap_data  = base + 8'(idx);
      cap_last  = (idx == n - 1);
      utx_full  = (cyc >= ffrom && cyc < fto);
      #2;
      if (utx_full && cap_ready) rwf++;
      acc = cap_ready;
      step();
      if (acc) idx++;
      cyc++;
    end
    cap_valid = 1'b0;
    cap_last  = 1'b0;
    utx_full  = 1'b0;
    sent = idx;
  endtask

  initial begin
    int sent, rwf, mism;

    // Reset values
    step();
    step();
    chk("rst_utx_write", utx_write, 1'b0);
    chk("rst_utx_data", utx_data, 8'h00);
    chk("rst_owner", owner, 2'b00);
    chk("rst_pending", cpu_pending, 1'b0);
    chk("rst_overrun", cpu_overrun, 1'b0);
    chk("rst_cap_ready", cap_ready, 1'b0);
    reset = 1'b0;

    // Single processor byte 0x41
    cpu_write = 1'b1; cpu_data = 8'h41;
    step();
    cpu_write = 1'b0;
    chk("c41_pending", cpu_pending, 1'b1);
    chk("c41_owner_idle", owner, 2'b00);
    step();
    chk("c41_owner_cpu", owner, 2'b01);
    chk("c41_no_write_yet", utx_write, 1'b0);
    step();
    chk("c41_write", utx_write, 1'b1);
    chk("c41_data", utx_data, 8'h41);
    chk("c41_owner_back", owner, 2'b00);
    chk("c41_pending_clr", cpu_pending, 1'b0);
    step();
    chk("c41_single_pulse", utx_write, 1'b0);
    chk("c41_data_held", utx_data, 8'h41);

    // Overrun while buffer full
    wq.delete();
    utx_full = 1'b1;
    cpu_write = 1'b1; cpu_data = 8'h10;
    step();
    cpu_data = 8'h11;
    step();
    cpu_write = 1'b0;
    chk("ovr_pending", cpu_pending, 1'b1);
    chk("ovr_flag", cpu_overrun, 1'b1);
    repeat (3) step();
    chk("ovr_no_write_full", wq.size(), 0);
    utx_full = 1'b0;
    repeat (4) step();
    chk("ovr_write_count", wq.size(), 1);
    chk("ovr_write_data", wq[0], 8'h10);
    chk("ovr_flag_sticky", cpu_overrun, 1'b1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("ovr_cleared", cpu_overrun, 1'b0);

    // Overrun and clear in the same cycle: set wins
    utx_full = 1'b1;
    cpu_write = 1'b1; cpu_data = 8'h30;
    step();
    cpu_data = 8'h31; clr_overrun = 1'b1;
    step();
    cpu_write = 1'b0; clr_overrun = 1'b0;
    chk("ovr_set_wins", cpu_overrun, 1'b1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    utx_full = 1'b0;
    repeat (4) step();
    chk("ovr2_last_data", wq[wq.size()-1], 8'h30);
    chk("ovr2_write_count", wq.size(), 2);

    // Write arriving in the drain cycle is accepted
    cpu_write = 1'b1; cpu_data = 8'h20;
    step();
    cpu_write = 1'b0;
    step();
    cpu_write = 1'b1; cpu_data = 8'h21;
    step();
    cpu_write = 1'b0;
    chk("drain_no_overrun", cpu_overrun, 1'b0);
    chk("drain_reload", cpu_pending, 1'b1);
    chk("drain_write", utx_write, 1'b1);
    chk("drain_data", utx_data, 8'h20);
    step();
    step();
    chk("drain_second_write", utx_write, 1'b1);
    chk("drain_second_data", utx_data, 8'h21);
    step();

    // 40-byte frame split into 16/16/8 grants
    wq.delete(); grants.delete(); adj = 0;
    send_cap(40, 8'h80, 0, 0, sent, rwf);
    repeat (3) step();
    chk("burst_sent", sent, 40);
    chk("burst_write_count", wq.size(), 40);
    mism = 0;
    for (int i = 0; i < wq.size(); i++) if (wq[i] !== 8'h80 + 8'(i)) mism++;
    chk("burst_stream", mism, 0);
    chk("burst_grant_count", grants.size(), 3);
    if (grants.size() == 3) begin
      chk("burst_grant0", grants[0], 16);
      chk("burst_grant1", grants[1], 16);
      chk("burst_grant2", grants[2], 8);
    end
    chk("burst_no_adjacent", adj, 0);

    // Round-robin tie after reset
    do_reset();
    wq.delete();
    cpu_write = 1'b1; cpu_data = 8'h60;
    step();
    cpu_write = 1'b0;
    cap_valid = 1'b1; cap_last = 1'b1; cap_data = 8'h55;
    step();
    chk("rr_first_cpu", owner, 2'b01);
    step();
    chk("rr_cpu_write", utx_data, 8'h60);
    chk("rr_idle", owner, 2'b00);
    step();
    chk("rr_then_cap", owner, 2'b10);
    cpu_write = 1'b1; cpu_data = 8'h61;
    step();
    cpu_write = 1'b0;
    chk("rr_cap_write", utx_data, 8'h55);
    chk("rr_cap_done", owner, 2'b00);
    step();
    chk("rr_second_tie_cpu", owner, 2'b01);
    cap_valid = 1'b0; cap_last = 1'b0;
    step();
    chk("rr_cpu2_write", utx_write, 1'b1);
    chk("rr_cpu2_data", utx_data, 8'h61);
    repeat (2) step();
    chk("rr_write_count", wq.size(), 3);

    // Buffer full mid-burst, half-full toggled
    wq.delete(); adj = 0; full_wr = 0;
    utx_half_full = 1'b1;
    send_cap(12, 8'hA0, 5, 12, sent, rwf);
    utx_half_full = 1'b0;
    repeat (3) step();
    chk("full_sent", sent, 12);
    chk("full_ready_low", rwf, 0);
    chk("full_no_writes", full_wr, 0);
    chk("full_write_count", wq.size(), 12);
    mism = 0;
    for (int i = 0; i < wq.size(); i++) if (wq[i] !== 8'hA0 + 8'(i)) mism++;
    chk("full_stream", mism, 0);
    chk("full_no_adjacent", adj, 0);

    // Reset on the cycle of a capture accept, with a byte also held
    cap_valid = 1'b1; cap_last = 1'b0; cap_data = 8'h77;
    cpu_write = 1'b1; cpu_data = 8'h99;
    step();
    cpu_write = 1'b0;
    chk("rstacc_in_cap", owner, 2'b10);
    chk("rstacc_ready", cap_ready, 1'b1);
    reset = 1'b1;
    wq.delete();
    #1;
    chk("rstacc_ready_in_reset", cap_ready, 1'b0);
    step();
    reset = 1'b0;
    cap_valid = 1'b0;
    chk("rstacc_write", utx_write, 1'b0);
    chk("rstacc_data", utx_data, 8'h00);
    chk("rstacc_owner", owner, 2'b00);
    chk("rstacc_pending", cpu_pending, 1'b0);
    chk("rstacc_overrun", cpu_overrun, 1'b0);
    repeat (4) step();
    chk("rstacc_no_writes", wq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
